regfile_stack_ctrl: RTL
=======================

// Module: regfile_stack_ctrl
// PURPOSE
//  Upstream sequencer for the stacked register file. Turns interrupt-entry and
//  interrupt-exit requests from the core/interrupt controller into one-cycle
//  Command_push / Command_pop pulses (RegFilePkg::Command). Tracks nesting depth,
//  selects the EABI or IABI global/stack mask pair, and stalls the pipeline while
//  a stack operation is in flight. Flags overflow and underflow.
// PARAMETERS
//  Depth  4  max number of stacked frames (push levels); depth counter width = $clog2(Depth+1)
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst          in   1   asynchronous, active-high reset
//  i_take         in   1   interrupt-entry request; held until o_take_ack
//  o_take_ack     out  1   entry accepted (combinational, IDLE only)
//  i_exit         in   1   interrupt-exit (mret) request; held until o_exit_ack
//  o_exit_ack     out  1   exit accepted (combinational, IDLE only)
//  i_iabi         in   1   1 = IABI masks, 0 = EABI masks; sampled on accept
//  o_cmd          out  2   Command to regfile: none / push / pop (registered)
//  o_mask_global  out  32  global mask for current op (registered)
//  o_mask_stack   out  32  stack mask for current op (registered)
//  o_depth        out  W   current nesting depth, 0..Depth
//  o_stall        out  1   1 while state != IDLE
//  o_overflow     out  1   sticky: entry refused at depth == Depth
//  o_underflow    out  1   sticky: exit at depth == 0
//  i_clr_err      in   1   clears both sticky flags (next edge)
// BEHAVIOUR
//  Reset: state=IDLE, o_cmd=none, o_depth=0, o_stall=0, flags=0, masks=EABI pair.
//  FSM IDLE -> ISSUE -> SETTLE -> IDLE. ISSUE and SETTLE last exactly 1 cycle each.
//  - IDLE: acks only here. Evaluate, in priority order:
//    a) i_take & i_exit & depth>0: tail-chain. Both acks=1, no cmd, depth
//       unchanged, stay IDLE (frame reused).
//    b) i_take & i_exit & depth==0: both acked; underflow set for the exit;
//       the take proceeds as a push. Case (c) rules apply to the take.
//    c) i_take, depth<Depth: take_ack=1. Next edge: state=ISSUE, o_cmd=push,
//       depth+1, masks latched from i_iabi.
//    d) i_take, depth==Depth: no ack, o_overflow<=1, stay IDLE. The request
//       is re-evaluated every cycle.
//    e) i_exit, depth>0: exit_ack=1. Next edge: ISSUE, o_cmd=pop, depth-1,
//       masks latched.
//    f) i_exit, depth==0: exit_ack=1, o_underflow<=1, no cmd, stay IDLE.
//  - ISSUE: o_cmd valid for this cycle only; next edge o_cmd=none, SETTLE.
//  - SETTLE: regfile shadow copy completes; next edge IDLE.
//  - Timing: the first new request can be acked 3 cycles after the previous ack.
//  - Masks hold their last value between ops.
//  - Depth never wraps: saturates at 0 and at Depth because of (d)/(f).
//  - i_clr_err in the same cycle as a new error: the set wins.
//  - Reset mid-op (ISSUE/SETTLE): immediate return to reset values, o_cmd=none.
// TESTING
//  1 reset, i_take=1, i_iabi=0 -> ack cycle 0; cyc1 cmd=push, depth=1, stall=1,
//    mask_stack=EABI; cyc3 IDLE, stall=0.
//  2 Depth=4: 5 takes -> depth=4; 5th not acked, overflow=1; i_clr_err -> 0.
//  3 depth=2, i_take & i_exit same cycle -> both acks, cmd stays none, depth=2,
//    stall=0.
//  4 depth=0, i_exit -> exit_ack=1, underflow=1, no pop, depth=0.
//  5 push with i_iabi=1 then pop with i_iabi=0 -> IABI masks on push,
//    EABI masks on pop.
//  6 assert i_rst during ISSUE -> o_cmd=none, depth=0, stall=0 in the same cycle.

Source files
------------

// File: rtl/regfile_stack_ctrl.sv
// Interrupt entry/exit sequencer for the stacked register file: issues one-cycle
// push/pop commands, tracks nesting depth, selects ABI masks and stalls the pipe.
module regfile_stack_ctrl #(
  parameter int unsigned Depth      = 4,
  parameter logic [31:0] EabiGlobal = 32'hFFFF_0000,
  parameter logic [31:0] EabiStack  = 32'h0000_FFFF,
  parameter logic [31:0] IabiGlobal = 32'hF000_000F,
  parameter logic [31:0] IabiStack  = 32'h0FFF_FFF0,
  localparam int unsigned DepthW    = $clog2(Depth + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_take,
  output logic              o_take_ack,
  input  logic              i_exit,
  output logic              o_exit_ack,
  input  logic              i_iabi,
  output logic [1:0]        o_cmd,
  output logic [31:0]       o_mask_global,
  output logic [31:0]       o_mask_stack,
  output logic [DepthW-1:0] o_depth,
  output logic              o_stall,
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic              i_clr_err
);

  localparam logic [1:0] CmdNone = 2'd0;
  localparam logic [1:0] CmdPush = 2'd1;
  localparam logic [1:0] CmdPop  = 2'd2;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIssue  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;

  logic [1:0]        state, stateNxt;
  logic [1:0]        cmd, cmdNxt;
  logic [DepthW-1:0] depth, depthNxt;
  logic [31:0]       maskGlobal, maskGlobalNxt;
  logic [31:0]       maskStack, maskStackNxt;
  logic              overflow, overflowNxt;
  logic              underflow, underflowNxt;
  logic              takeAck, exitAck;
  logic              setOvf, setUnf;
  logic              latchMasks;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= StIdle;
      cmd        <= CmdNone;
      depth      <= '0;
      maskGlobal <= EabiGlobal;
      maskStack  <= EabiStack;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= stateNxt;
      cmd        <= cmdNxt;
      depth      <= depthNxt;
      maskGlobal <= maskGlobalNxt;
      maskStack  <= maskStackNxt;
      overflow   <= overflowNxt;
      underflow  <= underflowNxt;
    end
  end

  // Request arbitration in IDLE; ISSUE and SETTLE are fixed single-cycle steps.
  always_comb begin
    stateNxt   = state;
    cmdNxt     = CmdNone;
    depthNxt   = depth;
    takeAck    = 1'b0;
    exitAck    = 1'b0;
    setOvf     = 1'b0;
    setUnf     = 1'b0;
    latchMasks = 1'b0;
    case (state)
      StIdle: begin
        if (i_take && i_exit && (depth != '0)) begin
          // Tail-chain: the outgoing frame is reused by the incoming one.
          takeAck = 1'b1;
          exitAck = 1'b1;
        end else if (i_take && (depth < DepthW'(Depth))) begin
          takeAck    = 1'b1;
          exitAck    = i_exit;
          setUnf     = i_exit;
          stateNxt   = StIssue;
          cmdNxt     = CmdPush;
          depthNxt   = depth + DepthW'(1);
          latchMasks = 1'b1;
        end else if (i_take) begin
          setOvf = 1'b1;
        end else if (i_exit && (depth != '0)) begin
          exitAck    = 1'b1;
          stateNxt   = StIssue;
          cmdNxt     = CmdPop;
          depthNxt   = depth - DepthW'(1);
          latchMasks = 1'b1;
        end else if (i_exit) begin
          exitAck = 1'b1;
          setUnf  = 1'b1;
        end
      end
      StIssue:  stateNxt = StSettle;
      StSettle: stateNxt = StIdle;
      default:  stateNxt = StIdle;
    endcase
  end

  always_comb begin
    maskGlobalNxt = maskGlobal;
    maskStackNxt  = maskStack;
    if (latchMasks) begin
      maskGlobalNxt = i_iabi ? IabiGlobal : EabiGlobal;
      maskStackNxt  = i_iabi ? IabiStack  : EabiStack;
    end
  end

  // A new error in the same cycle as a clear keeps the flag set.
  assign overflowNxt  = setOvf | (overflow & ~i_clr_err);
  assign underflowNxt = setUnf | (underflow & ~i_clr_err);

  assign o_take_ack    = takeAck;
  assign o_exit_ack    = exitAck;
  assign o_cmd         = cmd;
  assign o_mask_global = maskGlobal;
  assign o_mask_stack  = maskStack;
  assign o_depth       = depth;
  assign o_stall       = (state != StIdle);
  assign o_overflow    = overflow;
  assign o_underflow   = underflow;

endmodule
